// File: rtl/a5gx_starter_fpga_bup_qsys_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// The host side drives address and strobes; the PIO returns registered readdata.
interface a5gx_starter_fpga_bup_qsys_led_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/a5gx_starter_fpga_bup_qsys_led_pio.sv
// LED output PIO: DATA register with atomic set/clear aliases, registered out_port.
// Define LED_PIO_BLINK_EN to add the per-bit blink engine (BLINK_MASK / BLINK_PER).
module a5gx_starter_fpga_bup_qsys_led_pio #(
  parameter int unsigned       WIDTH       = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [31:0]       PERIOD_RST  = 32'd12_500_000
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  a5gx_starter_fpga_bup_qsys_led_pio_if.slave    bus,
  output logic [WIDTH-1:0]                       out_port
);

  typedef enum logic [2:0] {
    REG_DATA  = 3'd0,
    REG_RSVD1 = 3'd1,
    REG_MASK  = 3'd2,
    REG_PER   = 3'd3,
    REG_SET   = 3'd4,
    REG_CLR   = 3'd5,
    REG_RSVD6 = 3'd6,
    REG_RSVD7 = 3'd7
  } reg_addr_e;

  reg_addr_e        addr;
  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data;
  logic [31:0]      rd_next;

  assign addr  = reg_addr_e'(bus.address);
  assign wr_en = bus.chipselect & ~bus.write_n;
  assign wd    = bus.writedata[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr_en) begin
      case (addr)
        REG_DATA: data <= wd;
        REG_SET:  data <= data | wd;
        REG_CLR:  data <= data & ~wd;
        default:  ;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0] mask;
  logic [31:0]      per;
  logic [31:0]      cnt;
  logic             phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
    end else if (wr_en && addr == REG_MASK) begin
      mask <= wd;
    end
  end

  // A BLINK_PER write restarts the half-period so no shortened phase appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per   <= PERIOD_RST;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wr_en && addr == REG_PER) begin
      per   <= bus.writedata;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (per == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == per - 32'd1) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else begin
      out_port <= data & ~(mask & {WIDTH{phase}});
    end
  end

  always_comb begin
    rd_next = '0;
    case (addr)
      REG_DATA: rd_next[WIDTH-1:0] = data;
      REG_MASK: rd_next[WIDTH-1:0] = mask;
      REG_PER:  rd_next            = per;
      default:  ;
    endcase
  end
`else
  logic unused_wd;
  assign unused_wd = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else begin
      out_port <= data;
    end
  end

  always_comb begin
    rd_next = '0;
    case (addr)
      REG_DATA: rd_next[WIDTH-1:0] = data;
      default:  ;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

endmodule
